avalon_mm_mem_agent: RTL and testbench

Avalon-MM memory agent that terminates a host's memory-mapped bus. It consumes `s_avalon_mosi_t` from the interconnect and produces `s_avalon_miso_t` back to it. Backing store is an on-chip word array supporting single and burst reads/writes, with byte enables, wait-request flow control, read-data-valid pipelining and per-transaction error responses. It sits directly downstream of any Avalon host in the SoC and is the default target for bring-up and bus-verification traffic.

---
 rtl/avalon_mm_mem_agent_pkg.sv | 62 ++++++
 rtl/avalon_mm_mem_agent_chk.sv | 14 +
 rtl/avalon_sram_1p.sv | 36 +++
 rtl/avalon_mm_mem_agent.sv | 187 ++++++++++++++++++
 tb/tb_avalon_mm_mem_agent.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_mm_mem_agent_pkg.sv
// Shared Avalon-MM types and constants for the memory agent and its helpers.
package avalon_mm_mem_agent_pkg;

    localparam int AVALON_ADDR_WIDTH  = 32;
    localparam int AVALON_DATA_WIDTH  = 32;
    localparam int AVALON_BURST_WIDTH = 8;
    localparam int AVALON_BYTES       = AVALON_DATA_WIDTH / 8;

    localparam logic [1:0]                    AVALON_WR_RESP_VALID = 2'b01;
    localparam logic [AVALON_BURST_WIDTH-1:0] AVALON_BURST_ONE     = AVALON_BURST_WIDTH'(1);

    typedef enum logic [1:0] {
        AVALON_OKAY        = 2'b00,
        AVALON_RESERVED    = 2'b01,
        AVALON_SLVERR      = 2'b10,
        AVALON_DECODEERROR = 2'b11
    } avalon_resp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WR_BURST = 2'b01,
        RD_BURST = 2'b10
    } avalon_agent_st_t;

    typedef struct packed {
        logic [AVALON_ADDR_WIDTH-1:0]  address;
        logic [AVALON_BYTES-1:0]       byte_enable;
        logic                          read;
        logic                          write;
        logic [AVALON_DATA_WIDTH-1:0]  write_data;
        logic [AVALON_BURST_WIDTH-1:0] burst_count;
        logic                          begin_burst_transfer;
        logic                          lock;
        logic                          debug_access;
    } s_avalon_mosi_t;

    typedef struct packed {
        logic                         wait_request;
        logic [AVALON_DATA_WIDTH-1:0] read_data;
        logic                         read_data_valid;
        avalon_resp_t                 response;
        logic [1:0]                   write_response_valid;
    } s_avalon_miso_t;

    // A burst_count of zero means a single beat.
    function automatic logic [AVALON_BURST_WIDTH-1:0] burst_len(input logic [AVALON_BURST_WIDTH-1:0] bc);
        if (bc == '0) begin
            return AVALON_BURST_ONE;
        end else begin
            return bc;
        end
    endfunction

    function automatic avalon_resp_t resp_of(input logic err);
        if (err) begin
            return AVALON_SLVERR;
        end else begin
            return AVALON_OKAY;
        end
    endfunction

endpackage

// File: rtl/avalon_mm_mem_agent_chk.sv
// Protocol checks for the memory agent's host-facing port.
module avalon_mm_mem_agent_chk (
    input logic clk_i,
    input logic rst_n_i,
    input logic idle_i,
    input logic read_i,
    input logic write_i
);

    a_no_read_write_collision: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(idle_i && read_i && write_i)
    );

endmodule

// File: rtl/avalon_sram_1p.sv
// Single-port word array with byte-lane writes and a registered one-cycle read.
module avalon_sram_1p
    import avalon_mm_mem_agent_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk_i,
    input  logic                         en_i,
    input  logic                         we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
    input  logic [AVALON_BYTES-1:0]      be_i,
    input  logic [AVALON_DATA_WIDTH-1:0] wdata_i,
    output logic [AVALON_DATA_WIDTH-1:0] rdata_o
);

    logic [AVALON_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [AVALON_DATA_WIDTH-1:0] rdata_q;

    // Array access: masked write or registered read; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < AVALON_BYTES; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_mm_mem_agent.sv
// Avalon-MM agent terminating a host onto an on-chip SRAM with bursts and responses.
module avalon_mm_mem_agent
    import avalon_mm_mem_agent_pkg::*;
#(
    parameter int                           MEM_WORDS = 1024,
    parameter logic [AVALON_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic           aclk,
    input  logic           arst,
    input  s_avalon_mosi_t mosi,
    output s_avalon_miso_t miso
);

    localparam int AW         = $clog2(MEM_WORDS);
    // Wide enough that base + beat never wraps back into range.
    localparam int IW         = ((AW > AVALON_BURST_WIDTH) ? AW : AVALON_BURST_WIDTH) + 1;
    localparam int BYTE_SHIFT = $clog2(AVALON_BYTES);

    avalon_agent_st_t              state_q, state_d;
    logic [IW-1:0]                 base_q, base_d;
    logic                          soor_q, soor_d;
    logic [AVALON_BURST_WIDTH-1:0] cnt_q, cnt_d;
    logic [AVALON_BURST_WIDTH-1:0] len_q, len_d;
    logic                          err_q, err_d;
    logic                          wait_q, wait_d;
    logic                          rvalid_q, rvalid_d;
    logic                          rerr_q, rerr_d;
    logic                          wresp_q, wresp_d;
    avalon_resp_t                  resp_q, resp_d;

    logic [AVALON_ADDR_WIDTH-1:0]  word_s;
    logic                          cmd_oor_s;
    logic [AVALON_BURST_WIDTH-1:0] cmd_len_s;
    logic [IW-1:0]                 beat_idx_s;
    logic                          beat_oor_s;
    logic                          mem_en_s;
    logic                          mem_we_s;
    logic [AW-1:0]                 mem_addr_s;
    logic [AVALON_DATA_WIDTH-1:0]  mem_rdata_s;
    logic                          unused_ok_s;

    assign word_s     = (mosi.address - BASE_ADDR) >> BYTE_SHIFT;
    assign cmd_oor_s  = (mosi.address < BASE_ADDR) || (word_s >= AVALON_ADDR_WIDTH'(MEM_WORDS));
    assign cmd_len_s  = burst_len(mosi.burst_count);
    assign beat_idx_s = base_q + IW'(cnt_q);
    assign beat_oor_s = soor_q || (beat_idx_s >= IW'(MEM_WORDS));
    assign unused_ok_s = ^{mosi.lock, mosi.debug_access, mosi.begin_burst_transfer};

    // Next-state, beat sequencing and response generation.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        soor_d     = soor_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        err_d      = err_q;
        wait_d     = 1'b0;
        rvalid_d   = 1'b0;
        rerr_d     = 1'b0;
        wresp_d    = 1'b0;
        resp_d     = AVALON_OKAY;
        mem_en_s   = 1'b0;
        mem_we_s   = 1'b0;
        mem_addr_s = beat_idx_s[AW-1:0];
        case (state_q)
            IDLE: begin
                mem_addr_s = word_s[AW-1:0];
                base_d     = word_s[IW-1:0];
                soor_d     = cmd_oor_s;
                len_d      = cmd_len_s;
                if (wait_q) begin
                    state_d = IDLE;
                end else if (mosi.write) begin
                    mem_en_s = !cmd_oor_s;
                    mem_we_s = 1'b1;
                    cnt_d    = AVALON_BURST_ONE;
                    if (cmd_len_s > AVALON_BURST_ONE) begin
                        state_d = WR_BURST;
                        err_d   = cmd_oor_s;
                    end else begin
                        wresp_d = 1'b1;
                        resp_d  = resp_of(cmd_oor_s);
                        err_d   = 1'b0;
                    end
                end else if (mosi.read) begin
                    mem_en_s = !cmd_oor_s;
                    cnt_d    = AVALON_BURST_ONE;
                    state_d  = RD_BURST;
                    rvalid_d = 1'b1;
                    rerr_d   = cmd_oor_s;
                    resp_d   = resp_of(cmd_oor_s);
                    wait_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (mosi.write) begin
                    mem_en_s = !beat_oor_s;
                    mem_we_s = 1'b1;
                    cnt_d    = cnt_q + AVALON_BURST_ONE;
                    if ((cnt_q + AVALON_BURST_ONE) == len_q) begin
                        state_d = IDLE;
                        wresp_d = 1'b1;
                        resp_d  = resp_of(err_q || beat_oor_s);
                        err_d   = 1'b0;
                    end else begin
                        err_d = err_q || beat_oor_s;
                    end
                end else begin
                    state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                if (cnt_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    mem_en_s = !beat_oor_s;
                    cnt_d    = cnt_q + AVALON_BURST_ONE;
                    rvalid_d = 1'b1;
                    rerr_d   = beat_oor_s;
                    resp_d   = resp_of(beat_oor_s);
                    wait_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset aborts any burst in flight.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            soor_q   <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            wait_q   <= 1'b1;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            wresp_q  <= 1'b0;
            resp_q   <= AVALON_OKAY;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            soor_q   <= soor_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            wresp_q  <= wresp_d;
            resp_q   <= resp_d;
        end
    end

    avalon_sram_1p #(
        .MEM_WORDS (MEM_WORDS)
    ) u_sram (
        .clk_i   (aclk),
        .en_i    (mem_en_s),
        .we_i    (mem_we_s),
        .addr_i  (mem_addr_s),
        .be_i    (mosi.byte_enable),
        .wdata_i (mosi.write_data),
        .rdata_o (mem_rdata_s)
    );

    avalon_mm_mem_agent_chk u_chk (
        .clk_i   (aclk),
        .rst_n_i (arst),
        .idle_i  ((state_q == IDLE) && !wait_q),
        .read_i  (mosi.read),
        .write_i (mosi.write)
    );

    assign miso.wait_request         = wait_q;
    assign miso.read_data            = (rvalid_q && !rerr_q) ? mem_rdata_s : '0;
    assign miso.read_data_valid      = rvalid_q;
    assign miso.response             = resp_q;
    assign miso.write_response_valid = wresp_q ? AVALON_WR_RESP_VALID : 2'b00;

endmodule

// File: tb/tb_avalon_mm_mem_agent.sv
// Self-checking bench: directed vector table, burst corner cases and random traffic vs a word-array model.
module tb_avalon_mm_mem_agent;
    import avalon_mm_mem_agent_pkg::*;

    localparam int                           MEM_WORDS = 64;
    localparam logic [AVALON_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000;

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [7:0]   bc;
        logic [3:0]   be;
        logic [31:0]  wdata;
        logic [31:0]  exp_data;
        avalon_resp_t exp_resp;
    } vec_t;

    logic           aclk = 1'b0;
    logic           arst;
    s_avalon_mosi_t mosi;
    s_avalon_miso_t miso;

    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  model_mem [MEM_WORDS];
    logic [31:0]  wbuf [16];
    logic [31:0]  rbuf [16];
    avalon_resp_t rresp [16];
    vec_t         vecs [11];

    always #5 aclk = ~aclk;

    avalon_mm_mem_agent #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .aclk (aclk),
        .arst (arst),
        .mosi (mosi),
        .miso (miso)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr, input int beat);
        longint idx;
        if (longint'(addr) < longint'(BASE_ADDR)) return 1'b0;
        idx = (longint'(addr) - longint'(BASE_ADDR)) / AVALON_BYTES + beat;
        return idx < MEM_WORDS;
    endfunction

    function automatic int word_of(input logic [31:0] addr, input int beat);
        return int'((longint'(addr) - longint'(BASE_ADDR)) / AVALON_BYTES) + beat;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] bc, input logic [3:0] be,
                            input int stall_at, input int stall_cyc, input bit tail,
                            output avalon_resp_t resp);
        int n;
        bit exp_err;
        n = (bc == 8'd0) ? 1 : int'(bc);
        exp_err = 1'b0;
        check("wr_ready", miso.wait_request, 1'b0);
        for (int i = 0; i < n; i++) begin
            mosi.write = 1'b1; mosi.address = addr; mosi.burst_count = bc;
            mosi.byte_enable = be; mosi.write_data = wbuf[i];
            tick();
            if (in_range(addr, i)) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[word_of(addr, i)][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end else begin
                exp_err = 1'b1;
            end
            if (i < n - 1) begin
                check("wr_resp_early", miso.write_response_valid, 2'b00);
                if (i == stall_at) begin
                    mosi.write = 1'b0;
                    mosi.write_data = $urandom;
                    for (int s = 0; s < stall_cyc; s++) begin
                        tick();
                        check("wr_stall_resp", miso.write_response_valid, 2'b00);
                    end
                end
            end
        end
        mosi.write = 1'b0;
        resp = miso.response;
        check("wr_resp_valid", miso.write_response_valid, 2'b01);
        check("wr_resp", miso.response, exp_err ? AVALON_SLVERR : AVALON_OKAY);
        if (tail) begin
            tick();
            check("wr_resp_once", miso.write_response_valid, 2'b00);
            check("wr_resp_idle", miso.response, AVALON_OKAY);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] bc);
        int n;
        n = (bc == 8'd0) ? 1 : int'(bc);
        check("rd_ready", miso.wait_request, 1'b0);
        mosi.address = addr; mosi.burst_count = bc; mosi.read = 1'b1; mosi.byte_enable = 4'hF;
        tick();
        mosi.read = 1'b0;
        for (int k = 0; k < n; k++) begin
            bit ok;
            ok = in_range(addr, k);
            rbuf[k]  = miso.read_data;
            rresp[k] = miso.response;
            check("rd_valid", miso.read_data_valid, 1'b1);
            check("rd_wait", miso.wait_request, 1'b1);
            check("rd_data", miso.read_data, ok ? model_mem[word_of(addr, k)] : 32'h0);
            check("rd_resp", miso.response, ok ? AVALON_OKAY : AVALON_SLVERR);
            if (k < n - 1) tick();
        end
        tick();
        check("rd_valid_end", miso.read_data_valid, 1'b0);
        check("rd_wait_end", miso.wait_request, 1'b0);
    endtask

    initial begin
        avalon_resp_t r;
        arst = 1'b0;
        mosi = '0;
        for (int w = 0; w < MEM_WORDS; w++) model_mem[w] = 32'h0;

        // Reset sequence.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_wait", miso.wait_request, 1'b1);
            check("rst_rdata", miso.read_data, 32'h0);
            check("rst_rdv", miso.read_data_valid, 1'b0);
            check("rst_wrv", miso.write_response_valid, 2'b00);
            check("rst_resp", miso.response, AVALON_OKAY);
        end
        arst = 1'b1;
        #1;
        check("rel_wait_hold", miso.wait_request, 1'b1);
        tick();
        check("rel_wait", miso.wait_request, 1'b0);
        check("rel_rdv", miso.read_data_valid, 1'b0);

        // Pre-clear the backing store.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h0;
        for (int w = 0; w < MEM_WORDS; w += 8) do_write(32'(w * 4), 8'd8, 4'hF, -1, 0, 1'b1, r);

        // Directed single-beat table.
        vecs[0]  = '{1'b1, 32'h10,       8'd1, 4'b0101, 32'hDEADBEEF, 32'h0,        AVALON_OKAY};
        vecs[1]  = '{1'b0, 32'h10,       8'd1, 4'b1111, 32'h0,        32'h00AD00EF, AVALON_OKAY};
        vecs[2]  = '{1'b1, 32'h13,       8'd1, 4'b1010, 32'hCAFEF00D, 32'h0,        AVALON_OKAY};
        vecs[3]  = '{1'b0, 32'h12,       8'd1, 4'b1111, 32'h0,        32'hCAADF0EF, AVALON_OKAY};
        vecs[4]  = '{1'b1, 32'h100,      8'd1, 4'b1111, 32'h11111111, 32'h0,        AVALON_SLVERR};
        vecs[5]  = '{1'b0, 32'h100,      8'd1, 4'b1111, 32'h0,        32'h0,        AVALON_SLVERR};
        vecs[6]  = '{1'b1, 32'hFC,       8'd0, 4'b1111, 32'h12345678, 32'h0,        AVALON_OKAY};
        vecs[7]  = '{1'b0, 32'hFC,       8'd0, 4'b1111, 32'h0,        32'h12345678, AVALON_OKAY};
        vecs[8]  = '{1'b0, 32'hFFFFFFFC, 8'd1, 4'b1111, 32'h0,        32'h0,        AVALON_SLVERR};
        vecs[9]  = '{1'b1, 32'h14,       8'd1, 4'b0000, 32'hFFFFFFFF, 32'h0,        AVALON_OKAY};
        vecs[10] = '{1'b0, 32'h14,       8'd1, 4'b1111, 32'h0,        32'h0,        AVALON_OKAY};
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].is_wr) begin
                wbuf[0] = vecs[v].wdata;
                do_write(vecs[v].addr, vecs[v].bc, vecs[v].be, -1, 0, 1'b1, r);
                check("tbl_wr_resp", r, vecs[v].exp_resp);
            end else begin
                do_read(vecs[v].addr, vecs[v].bc);
                check("tbl_rd_data", rbuf[0], vecs[v].exp_data);
                check("tbl_rd_resp", rresp[0], vecs[v].exp_resp);
            end
        end

        // Write burst with a two-cycle host stall after beat 1.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(32'h0, 8'd4, 4'hF, 1, 2, 1'b1, r);
        check("stall_wr_resp", r, AVALON_OKAY);
        do_read(32'h0, 8'd4);
        for (int i = 0; i < 4; i++) check("stall_readback", rbuf[i], 32'(i + 1));

        // Read burst running off the top of memory.
        do_read(32'((MEM_WORDS - 2) * 4), 8'd3);
        check("top_resp0", rresp[0], AVALON_OKAY);
        check("top_resp1", rresp[1], AVALON_OKAY);
        check("top_resp2", rresp[2], AVALON_SLVERR);
        check("top_data2", rbuf[2], 32'h0);

        // Write burst entirely beyond memory.
        wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
        do_write(BASE_ADDR + 32'(4 * MEM_WORDS), 8'd2, 4'hF, -1, 0, 1'b1, r);
        check("oor_wr_resp", r, AVALON_SLVERR);

        // Reset in the middle of an 8-beat read.
        mosi.address = 32'h0; mosi.burst_count = 8'd8; mosi.read = 1'b1;
        tick();
        mosi.read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("mid_rst_beat", miso.read_data, model_mem[k]);
            if (k < 2) tick();
        end
        #2 arst = 1'b0;
        #1;
        check("mid_rst_rdv", miso.read_data_valid, 1'b0);
        check("mid_rst_wait", miso.wait_request, 1'b1);
        tick();
        tick();
        arst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("mid_rst_no_beat", miso.read_data_valid, 1'b0);
        end
        do_read(32'h0, 8'd8);

        // Randomised traffic against the model.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            logic [7:0]  bc;
            a  = 32'($urandom_range(0, MEM_WORDS + 2) * 4 + $urandom_range(0, 3));
            bc = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
                do_write(a, bc, 4'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                         1'($urandom_range(0, 1)), r);
            end else begin
                do_read(a, bc);
            end
        end

        // Full readback confirms nothing strayed into unintended words.
        for (int w = 0; w < MEM_WORDS; w += 8) do_read(32'(w * 4), 8'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
